// File: rtl/fifo_word_packer.sv
// Packs Ratio consecutive FIFO read words into one wide word.
// A flush emits a partial word; mask_o marks the filled lanes.
module fifo_word_packer #(
  parameter int unsigned InW   = 32,
  parameter int unsigned Ratio = 2,
  parameter int unsigned CntW  = $clog2(Ratio + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [InW-1:0]       data_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [InW*Ratio-1:0] data_o,
  output logic [Ratio-1:0]     mask_o,
  output logic [CntW-1:0]      cnt_o
);

  localparam logic [CntW-1:0] Full = CntW'(Ratio);

  logic [Ratio-1:0][InW-1:0] lane_q;
  logic [CntW-1:0]           cnt_q;
  logic                      flush_q;
  logic                      acc;
  logic                      out_hs;
  logic [CntW-1:0]           cnt_acc;
  logic                      flush_set;

  assign valid_o = (cnt_q == Full) | flush_q;
  assign ready_o = ~flush_q & ((cnt_q < Full) | ready_i);
  assign acc     = valid_i & ready_o;
  assign out_hs  = valid_o & ready_i;
  assign cnt_acc = cnt_q + CntW'(acc);

  // A flush only opens a word that is non-empty and not already full.
  assign flush_set = flush_i & ~valid_o
                   & (cnt_acc != '0) & (cnt_acc < Full);

  assign data_o = lane_q;
  assign cnt_o  = cnt_q;

  always_comb begin
    mask_o = '0;
    for (int k = 0; k < Ratio; k++) begin
      mask_o[k] = (CntW'(k) < cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else if (clr_i) begin
      lane_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else if (out_hs) begin
      lane_q  <= '0;
      if (acc) lane_q[0] <= data_i;
      cnt_q   <= CntW'(acc);
      flush_q <= 1'b0;
    end else begin
      for (int k = 0; k < Ratio; k++) begin
        if (acc && cnt_q == CntW'(k)) lane_q[k] <= data_i;
      end
      cnt_q <= cnt_acc;
      if (flush_set) flush_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_o <= Full);
  a_mask_nz: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> mask_o != '0);
  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o && !ready_i && !clr_i
      |=> $stable(data_o) && $stable(mask_o));
  a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(valid_o) && !$isunknown(ready_o));
  a_known_d: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> !$isunknown(data_o));
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: vector table on Ratio=2, corner
// sequences and a scoreboarded random run on Ratio=4.
module tb_fifo_word_packer;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic        clr2, v2, fl2, rdy2, ro2, vo2;
  logic [31:0] d2;
  logic [63:0] do2;
  logic [1:0]  m2, c2;

  logic         clr4, v4, fl4, rdy4, ro4, vo4;
  logic [31:0]  d4;
  logic [127:0] do4;
  logic [3:0]   m4;
  logic [2:0]   c4;

  fifo_word_packer #(.InW(32), .Ratio(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr2),
    .valid_i(v2), .ready_o(ro2), .data_i(d2),
    .flush_i(fl2), .valid_o(vo2), .ready_i(rdy2),
    .data_o(do2), .mask_o(m2), .cnt_o(c2));

  fifo_word_packer #(.InW(32), .Ratio(4)) u4 (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr4),
    .valid_i(v4), .ready_o(ro4), .data_i(d4),
    .flush_i(fl4), .valid_o(vo4), .ready_i(rdy4),
    .data_o(do4), .mask_o(m4), .cnt_o(c4));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        clr, v;
    logic [31:0] d;
    logic        fl, rdy;
    logic        ev, er;
    logic [63:0] ed;
    logic [1:0]  em, ec;
  } vec_t;

  function automatic vec_t mk(logic c, logic v, logic [31:0] d,
      logic f, logic r, logic ev, logic er, logic [63:0] ed,
      logic [1:0] em, logic [1:0] ec);
    vec_t t;
    t.clr = c; t.v = v; t.d = d; t.fl = f; t.rdy = r;
    t.ev = ev; t.er = er; t.ed = ed; t.em = em; t.ec = ec;
    return t;
  endfunction

  task automatic cyc4(input logic c, input logic v,
      input logic [31:0] d, input logic f, input logic r);
    @(negedge clk);
    clr4 = c; v4 = v; d4 = d; fl4 = f; rdy4 = r;
    #1;
  endtask

  typedef struct {
    logic [127:0] d;
    logic [3:0]   m;
  } exp_t;

  exp_t             sbq[$];
  logic [3:0][31:0] pw;
  int               mc;
  bit               mp;

  task automatic sb_cycle(input logic v, input logic [31:0] d,
                          input logic f, input logic r);
    logic ev, er, acc, hs;
    exp_t e;
    cyc4(1'b0, v, d, f, r);
    ev = (mc == 4) || mp;
    er = !mp && (mc < 4 || r);
    chk("sb_valid", vo4, ev);
    chk("sb_ready", ro4, er);
    acc = v & er;
    hs  = ev & r;
    if (hs) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", do4, e.d);
        chk("sb_mask", m4, e.m);
      end
      pw = '0; mc = 0; mp = 0;
      if (acc) begin pw[0] = d; mc = 1; end
    end else begin
      if (acc) begin
        pw[mc] = d;
        mc++;
        if (mc == 4) sbq.push_back('{pw, 4'hF});
      end
      if (f && !ev && mc > 0 && mc < 4) begin
        mp = 1;
        sbq.push_back('{pw, 4'((1 << mc) - 1)});
      end
    end
  endtask

  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    {clr2, v2, fl2} = '0; d2 = '0; rdy2 = 1'b1;
    {clr4, v4, fl4, rdy4} = '0; d4 = '0;
    tbl[0]  = mk(0, 0, 0,            0, 1, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 32'hAAAA0001, 0, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 32'hBBBB0002, 0, 1, 0, 1, 64'hAAAA0001, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 1, 64'hBBBB0002_AAAA0001, 3, 2);
    tbl[4]  = mk(0, 0, 0,     0, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1,     0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 2,     0, 0, 0, 1, 64'h1, 1, 1);
    tbl[7]  = mk(0, 1, 'hDEAD, 0, 0, 1, 0, 64'h2_00000001, 3, 2);
    tbl[8]  = mk(0, 1, 'hDEAD, 0, 0, 1, 0, 64'h2_00000001, 3, 2);
    tbl[9]  = mk(0, 1, 'hDEAD, 0, 0, 1, 0, 64'h2_00000001, 3, 2);
    tbl[10] = mk(0, 1, 'hC3,  0, 1, 1, 1, 64'h2_00000001, 3, 2);
    tbl[11] = mk(0, 0, 0,     0, 1, 0, 1, 64'hC3, 1, 1);
    tbl[12] = mk(0, 1, 'h44,  0, 1, 0, 1, 64'hC3, 1, 1);
    tbl[13] = mk(0, 0, 0,     0, 1, 1, 1, 64'h44_000000C3, 3, 2);
    tbl[14] = mk(0, 1, 'h55,  0, 1, 0, 1, 0, 0, 0);
    tbl[15] = mk(1, 1, 'h66,  1, 1, 0, 1, 64'h55, 1, 1);
    tbl[16] = mk(0, 0, 0,     0, 1, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0,     1, 1, 0, 1, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,     0, 1, 0, 1, 0, 0, 0);
    tbl[19] = mk(0, 1, 'h77,  0, 1, 0, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0,     1, 0, 0, 1, 64'h77, 1, 1);
    tbl[21] = mk(0, 1, 'h88,  0, 0, 1, 0, 64'h77, 1, 1);
    tbl[22] = mk(0, 1, 'h99,  0, 1, 1, 0, 64'h77, 1, 1);
    tbl[23] = mk(0, 0, 0,     0, 1, 0, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_valid", vo2, 0);
    chk("rst_ready", ro2, 1);
    chk("rst_mask", m2, 0);
    chk("rst_data", do2, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      clr2 = tbl[i].clr; v2 = tbl[i].v; d2 = tbl[i].d;
      fl2 = tbl[i].fl; rdy2 = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_valid", i), vo2, tbl[i].ev);
      chk($sformatf("row%0d_ready", i), ro2, tbl[i].er);
      chk($sformatf("row%0d_data", i), do2, tbl[i].ed);
      chk($sformatf("row%0d_mask", i), m2, tbl[i].em);
      chk($sformatf("row%0d_cnt", i), c2, tbl[i].ec);
    end

    // Ratio=4 partial flush of two beats
    cyc4(0, 1, 'h11, 0, 0);
    cyc4(0, 1, 'h22, 0, 0);
    cyc4(0, 0, 0, 1, 0);
    cyc4(0, 1, 'h33, 0, 0);
    chk("fl_valid", vo4, 1);
    chk("fl_mask", m4, 4'b0011);
    chk("fl_data", do4, 128'h22_00000011);
    chk("fl_ready", ro4, 0);
    chk("fl_cnt", c4, 2);
    cyc4(0, 1, 'h33, 0, 0);
    chk("fl_hold", do4, 128'h22_00000011);
    cyc4(0, 0, 0, 0, 1);
    chk("fl_ready_hs", ro4, 0);
    cyc4(0, 0, 0, 0, 1);
    chk("fl_done_valid", vo4, 0);
    chk("fl_done_cnt", c4, 0);
    chk("fl_done_mask", m4, 0);

    cyc4(0, 0, 0, 1, 1);
    cyc4(0, 0, 0, 0, 1);
    chk("fl_empty_valid", vo4, 0);

    cyc4(0, 1, 1, 0, 0);
    cyc4(0, 1, 2, 0, 0);
    cyc4(0, 1, 3, 0, 0);
    cyc4(0, 1, 4, 1, 0);
    cyc4(0, 0, 0, 0, 0);
    chk("fl4_valid", vo4, 1);
    chk("fl4_mask", m4, 4'hF);
    chk("fl4_cnt", c4, 4);
    chk("fl4_data", do4, 128'h4_00000003_00000002_00000001);
    cyc4(0, 0, 0, 0, 1);
    cyc4(0, 0, 0, 0, 1);
    chk("fl4_done_valid", vo4, 0);
    chk("fl4_done_ready", ro4, 1);

    // Async reset in the middle of a word
    @(negedge clk);
    clr2 = 0; v2 = 1; d2 = 'h1234; fl2 = 0; rdy2 = 1;
    @(negedge clk);
    v2 = 0;
    #1;
    chk("mid_cnt_pre", c2, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", vo2, 0);
    chk("mid_rst_mask", m2, 0);
    chk("mid_rst_ready", ro2, 1);
    chk("mid_rst_cnt", c2, 0);
    chk("mid_rst_data", do2, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    v2 = 1; d2 = 'h5001;
    @(negedge clk);
    d2 = 'h5002;
    @(negedge clk);
    v2 = 0;
    #1;
    chk("post_rst_valid", vo2, 1);
    chk("post_rst_data", do2, 64'h5002_00005001);

    // Random traffic against the scoreboard
    pw = '0; mc = 0; mp = 0;
    for (int i = 0; i < 400; i++) begin
      sb_cycle(1'($urandom_range(0, 3) != 0), $urandom,
               1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) sb_cycle(1'b0, '0, 1'b0, 1'b1);
    chk("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
